// File: rtl/fetch_decode_reg.sv
// Fetch/Decode pipeline register: pairs an immediate-flagged opcode with its
// following word, inserts a bubble meanwhile, and defers interrupts to instruction boundaries.
module fetch_decode_reg #(
  parameter int                WORD_W       = 16,
  parameter int                PC_W         = 32,
  parameter int                IMM_FLAG_BIT = 0,
  parameter logic [WORD_W-1:0] NOP_WORD     = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              fetchValid,
  input  logic [WORD_W-1:0] instrIn,
  input  logic [PC_W-1:0]   pcIn,
  input  logic [PC_W-1:0]   nextPcIn,
  input  logic              intIn,
  output logic [WORD_W-1:0] instrOut,
  output logic [WORD_W-1:0] immOut,
  output logic [PC_W-1:0]   pcOut,
  output logic [PC_W-1:0]   nextPcOut,
  output logic              validOut,
  output logic              hasImm,
  output logic              intTake
);

  typedef enum logic {OP, IMM} state_t;

  state_t            state, state_d;
  logic [WORD_W-1:0] held_op, held_op_d;
  logic [PC_W-1:0]   held_pc, held_pc_d;
  logic              int_pending, int_pending_d;

  logic [WORD_W-1:0] instr_d, imm_d;
  logic [PC_W-1:0]   pc_d, next_pc_d;
  logic              valid_d, has_imm_d, take_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= OP;
    else      state <= state_d;
  end

  always_comb begin
    state_d       = state;
    held_op_d     = held_op;
    held_pc_d     = held_pc;
    int_pending_d = int_pending | intIn;
    instr_d       = instrOut;
    imm_d         = immOut;
    pc_d          = pcOut;
    next_pc_d     = nextPcOut;
    valid_d       = validOut;
    has_imm_d     = hasImm;
    take_d        = 1'b0;

    if (flush) begin
      state_d   = OP;
      instr_d   = NOP_WORD;
      imm_d     = '0;
      valid_d   = 1'b0;
      has_imm_d = 1'b0;
    end else if (!stall) begin
      // Interrupts are only taken between instructions, never mid-pair.
      if (state == OP && int_pending) begin
        take_d        = 1'b1;
        int_pending_d = intIn;
      end
      instr_d   = NOP_WORD;
      imm_d     = '0;
      valid_d   = 1'b0;
      has_imm_d = 1'b0;
      if (fetchValid) begin
        case (state)
          OP: begin
            if (instrIn[IMM_FLAG_BIT]) begin
              held_op_d = instrIn;
              held_pc_d = pcIn;
              state_d   = IMM;
            end else begin
              instr_d   = instrIn;
              pc_d      = pcIn;
              next_pc_d = nextPcIn;
              valid_d   = 1'b1;
            end
          end
          IMM: begin
            instr_d   = held_op;
            imm_d     = instrIn;
            pc_d      = held_pc;
            next_pc_d = nextPcIn;
            valid_d   = 1'b1;
            has_imm_d = 1'b1;
            state_d   = OP;
          end
          default: state_d = OP;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held_op     <= '0;
      held_pc     <= '0;
      int_pending <= 1'b0;
      instrOut    <= NOP_WORD;
      immOut      <= '0;
      pcOut       <= '0;
      nextPcOut   <= '0;
      validOut    <= 1'b0;
      hasImm      <= 1'b0;
      intTake     <= 1'b0;
    end else begin
      held_op     <= held_op_d;
      held_pc     <= held_pc_d;
      int_pending <= int_pending_d;
      instrOut    <= instr_d;
      immOut      <= imm_d;
      pcOut       <= pc_d;
      nextPcOut   <= next_pc_d;
      validOut    <= valid_d;
      hasImm      <= has_imm_d;
      intTake     <= take_d;
    end
  end

endmodule

// File: tb/tb_fetch_decode_reg.sv
// Bench for fetch_decode_reg: directed scenarios plus random traffic, checked
// against an instruction-assembly reference model.
module tb_fetch_decode_reg;
  localparam int WORD_W = 16;
  localparam int PC_W   = 32;
  localparam logic [WORD_W-1:0] NOP = 16'h0;

  logic              clk = 0, rst = 0;
  logic              stall = 0, flush = 0, fetchValid = 0, intIn = 0;
  logic [WORD_W-1:0] instrIn = '0;
  logic [PC_W-1:0]   pcIn = '0, nextPcIn = '0;
  logic [WORD_W-1:0] instrOut, immOut;
  logic [PC_W-1:0]   pcOut, nextPcOut;
  logic              validOut, hasImm, intTake;

  fetch_decode_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .fetchValid(fetchValid),
    .instrIn(instrIn), .pcIn(pcIn), .nextPcIn(nextPcIn), .intIn(intIn),
    .instrOut(instrOut), .immOut(immOut), .pcOut(pcOut), .nextPcOut(nextPcOut),
    .validOut(validOut), .hasImm(hasImm), .intTake(intTake)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: a partially assembled instruction plus expected outputs.
  bit              partial, pend;
  logic [WORD_W-1:0] p_op;
  logic [PC_W-1:0]   p_pc;
  logic [WORD_W-1:0] e_instr, e_imm;
  logic [PC_W-1:0]   e_pc, e_npc;
  bit                e_valid, e_has, e_take;

  task automatic model_reset();
    partial = 0; pend = 0; p_op = '0; p_pc = '0;
    e_instr = NOP; e_imm = '0; e_pc = '0; e_npc = '0;
    e_valid = 0; e_has = 0; e_take = 0;
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".instr"}, 64'(instrOut), 64'(e_instr));
    chk({tag, ".imm"},   64'(immOut),   64'(e_imm));
    chk({tag, ".valid"}, 64'(validOut), 64'(e_valid));
    chk({tag, ".hasImm"},64'(hasImm),   64'(e_has));
    chk({tag, ".take"},  64'(intTake),  64'(e_take));
    if (e_valid) begin
      chk({tag, ".pc"},  64'(pcOut),     64'(e_pc));
      chk({tag, ".npc"}, 64'(nextPcOut), 64'(e_npc));
    end
  endtask

  task automatic step(input string tag, input bit st, input bit fl, input bit fv,
                      input logic [WORD_W-1:0] w, input logic [PC_W-1:0] pc,
                      input logic [PC_W-1:0] npc, input bit irq);
    @(negedge clk);
    stall = st; flush = fl; fetchValid = fv; instrIn = w; pcIn = pc; nextPcIn = npc; intIn = irq;
    if (fl) begin
      partial = 0; e_valid = 0; e_has = 0; e_instr = NOP; e_imm = '0; e_take = 0;
      pend = pend | irq;
    end else if (st) begin
      e_take = 0; pend = pend | irq;
    end else begin
      e_take = !partial && pend;
      pend = e_take ? irq : (pend | irq);
      e_valid = 0; e_has = 0; e_instr = NOP; e_imm = '0;
      if (fv) begin
        if (partial) begin
          e_valid = 1; e_has = 1; e_instr = p_op; e_imm = w; e_pc = p_pc; e_npc = npc;
          partial = 0;
        end else if (w[0]) begin
          partial = 1; p_op = w; p_pc = pc;
        end else begin
          e_valid = 1; e_instr = w; e_pc = pc; e_npc = npc;
        end
      end
    end
    @(posedge clk); #1;
    check_outs(tag);
  endtask

  logic [PC_W-1:0] rpc;

  initial begin
    model_reset();
    #12;
    check_outs("reset");
    chk("reset.pc", 64'(pcOut), 64'd0);
    chk("reset.npc", 64'(nextPcOut), 64'd0);
    @(negedge clk); rst = 1;

    // 1. plain stream
    step("t1a", 0, 0, 1, 16'h1000, 0, 1, 0);
    step("t1b", 0, 0, 1, 16'h2000, 1, 2, 0);
    // 2. opcode + immediate
    step("t2op",  0, 0, 1, 16'h4001, 8, 9, 0);
    step("t2imm", 0, 0, 1, 16'hBEEF, 9, 10, 0);
    chk("t2.npc", 64'(nextPcOut), 64'd10);
    // 3. stall while in IMM
    step("t3op", 0, 0, 1, 16'h4001, 20, 21, 0);
    for (int i = 0; i < 3; i++) step("t3stall", 1, 0, 1, 16'hBEEF, 21, 22, 0);
    step("t3imm", 0, 0, 1, 16'hBEEF, 21, 22, 0);
    // 4. flush beats stall while in IMM
    step("t4op", 0, 0, 1, 16'h4001, 30, 31, 0);
    step("t4flush", 1, 1, 1, 16'h1234, 31, 32, 0);
    step("t4next", 0, 0, 1, 16'h3000, 40, 41, 0);
    // 5. interrupt during IMM waits for the boundary
    step("t5op",  0, 0, 1, 16'h4001, 50, 51, 0);
    step("t5imm", 0, 0, 1, 16'hBEEF, 51, 52, 1);
    step("t5take", 0, 0, 1, 16'h1000, 52, 53, 0);
    chk("t5.pulse", 64'(intTake), 64'd1);
    step("t5after", 0, 0, 1, 16'h1000, 53, 54, 0);
    // 6. async reset mid-IMM
    step("t6op", 0, 0, 1, 16'h4001, 60, 61, 0);
    @(negedge clk); rst = 0; fetchValid = 0; #1;
    model_reset();
    check_outs("t6rst");
    @(negedge clk); rst = 1;
    step("t6after", 0, 0, 1, 16'h1000, 70, 71, 0);
    // wrap-around of pc
    step("wrap_op",  0, 0, 1, 16'h4001, 32'hFFFF_FFFF, 32'h0, 0);
    step("wrap_imm", 0, 0, 1, 16'h5555, 32'h0, 32'h1, 0);

    // random traffic
    rpc = 32'hFFFF_FF00;
    for (int i = 0; i < 400; i++) begin
      bit st, fl, fv, irq;
      st  = ($urandom_range(0, 9) == 0);
      fl  = ($urandom_range(0, 19) == 0);
      fv  = ($urandom_range(0, 4) != 0);
      irq = ($urandom_range(0, 14) == 0);
      step("rand", st, fl, fv, 16'($urandom), rpc, rpc + 1, irq);
      if (fv && !st) rpc = rpc + 1;
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
